// File: rtl/register_file_bank.sv
// Parametrised register bank: one write port, two registered read ports with same-cycle
// write-to-read bypass, and a sequencer that clears every entry one per cycle.
module register_file_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_valid_a,
    output logic                  rd_valid_b,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clear_done
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic                  busy_q, busy_d;
    logic                  clear_done_q, clear_done_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
    logic                  rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;

    logic accept, wr_commit;
    logic zero_a, zero_b, hit_a, hit_b;

    // Only in IDLE with no clear request are reads and writes taken; clear wins the edge.
    assign accept    = (state_q == StIdle) && !clear_req;
    assign wr_commit = accept && wr_en && !(ZERO_REG && (wr_addr == '0));
    assign zero_a    = ZERO_REG && (rd_addr_a == '0);
    assign zero_b    = ZERO_REG && (rd_addr_b == '0);
    assign hit_a     = wr_commit && (wr_addr == rd_addr_a);
    assign hit_b     = wr_commit && (wr_addr == rd_addr_b);

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        busy_d       = busy_q;
        clear_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                    busy_d    = 1'b1;
                end
            end
            StClear: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d      = StIdle;
                    busy_d       = 1'b0;
                    clear_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_data_a_d  = rd_data_a_q;
        rd_data_b_d  = rd_data_b_q;
        rd_valid_a_d = 1'b0;
        rd_valid_b_d = 1'b0;
        if (accept && rd_en_a) begin
            rd_valid_a_d = 1'b1;
            if (zero_a)     rd_data_a_d = '0;
            else if (hit_a) rd_data_a_d = wr_data;
            else            rd_data_a_d = mem_q[rd_addr_a];
        end
        if (accept && rd_en_b) begin
            rd_valid_b_d = 1'b1;
            if (zero_b)     rd_data_b_d = '0;
            else if (hit_b) rd_data_b_d = wr_data;
            else            rd_data_b_d = mem_q[rd_addr_b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            clr_idx_q    <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
            if (state_q == StClear) begin
                mem_q[clr_idx_q] <= '0;
            end else if (wr_commit) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;

endmodule

// File: doc/register_file_bank.md
# register_file_bank

Parametrised register bank with two registered read ports, one write port, same-cycle write-to-read bypass and a hardware bulk-clear sequencer. It replaces the hard-coded 4/8-way combinational read selection in the register file with a generic 2^ADDR_WIDTH-entry read path. It sits between decode (read addresses) and write-back (write port) in the datapath.

## Interface

**Parameters**
- DATA_WIDTH, 32, width of each register entry.
- ADDR_WIDTH, 5, address width; DEPTH = 2^ADDR_WIDTH entries.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero.

**Ports**
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write index.
- wr_data  in  DATA_WIDTH  write value.
- rd_en_a / rd_en_b  in  1  read request, port A / B.
- rd_addr_a / rd_addr_b  in  ADDR_WIDTH  read index.
- rd_data_a / rd_data_b  out  DATA_WIDTH  registered read data.
- rd_valid_a / rd_valid_b  out  1  rd_data updated by the previous cycle's request.
- clear_req  in  1  start bulk clear (pulse or level; sampled only in IDLE).
- busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse after the last entry is cleared.

## Operation

- Reset (async): all entries = 0, rd_data_* = 0, rd_valid_* = 0, busy = 0, clear_done = 0, state = IDLE, clear index = 0.
- Write (IDLE only): if wr_en, entry[wr_addr] <= wr_data at the edge. If ZERO_REG = 1 and wr_addr = 0, the write is dropped.
- Read, per port independently. On an edge with rd_en_x = 1 in IDLE:
  - rd_valid_x <= 1.
  - rd_data_x <= bypass value if wr_en && wr_addr == rd_addr_x and the write is not dropped; otherwise entry[rd_addr_x].
  - Reading address 0 with ZERO_REG = 1 always returns 0.
- If rd_en_x = 0 or busy: rd_valid_x <= 0 and rd_data_x holds its previous value.
- Both ports reading the same address is legal; both return identical data.
- FSM states:
  - IDLE: clear_req = 1 → CLEAR with index <= 0, busy <= 1. The wr_en and rd_en sampled on that same edge are ignored (clear has priority).
  - CLEAR: each edge sets entry[index] <= 0, index <= index + 1. wr_en, rd_en and clear_req are ignored. When index = DEPTH-1 → IDLE, busy <= 0, clear_done <= 1.
  - clear_done returns to 0 on the following edge.
- Index width is ADDR_WIDTH. The exit compare is on DEPTH-1, so there is no wrap.
- rst asserted mid-CLEAR aborts the clear; everything returns to reset values.

## Timing

- Read latency: 1 cycle. Request at edge N; data and rd_valid are visible after edge N, until edge N+1.
- Bypass is combinational from wr_data to the rd_data register input. It costs no extra cycle.
- Clear: clear_req sampled at edge N.
  - busy = 1 from edge N through edge N+DEPTH.
  - Entries 0..DEPTH-1 are cleared at edges N+1..N+DEPTH.
  - busy = 0 and clear_done = 1 after edge N+DEPTH.
  - The first accepted write/read is at edge N+DEPTH+1.
  - Total clear duration: DEPTH+1 edges, including the accept edge.
- No combinational path from any input to any output.

## Test plan

- Reset then read: assert rst, release, read A = 7 and B = 31 → after 1 cycle rd_data_a = rd_data_b = 0, both rd_valid = 1.
- Write/read: write 0xDEADBEEF to entry 5, next cycle read A = 5 → rd_data_a = 0xDEADBEEF one cycle later. Read B = 5 with rd_en_b = 0 → rd_valid_b = 0, rd_data_b unchanged.
- Bypass and zero register: in one cycle write 0x12345678 to entry 9 while A reads 9 → rd_data_a = 0x12345678 next cycle. Write 0xFFFFFFFF to entry 0, then read 0 → 0. Repeat with ZERO_REG = 0 → 0xFFFFFFFF.
- Bulk clear: fill all 32 entries with index+1, pulse clear_req → busy high for exactly 32 cycles after the accept edge, then clear_done pulses one cycle. Reads of 1, 17 and 31 return 0. A write issued mid-clear is lost, and reads issued mid-clear give rd_valid = 0.
- Simultaneous events: clear_req with wr_en (entry 3 = 0xA5) on the same edge → entry 3 reads 0 after the clear. clear_req re-asserted during CLEAR → no restart, clear_done fires once.
- Reset mid-clear: assert rst at cycle 10 of CLEAR → busy = 0, clear_done = 0, all reads 0. A new clear_req after release runs a full DEPTH-cycle clear. Repeat with DATA_WIDTH = 8, ADDR_WIDTH = 3 → 8-cycle clear.
